// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, SPI mode constants and
// helpers that split a mode number into its clock polarity and phase bits.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_GAP      = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_CS_IDLE  = 3'd5
  } state_e;

  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: while enabled, toggles SCLK every c_CLKS_PER_HALF_BIT cycles
// for 2*c_WIDTH edges; strobes fire in the cycle whose clock edge moves the pin.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int c_SPI_MODE          = 0,
  parameter int c_WIDTH             = 8,
  parameter int c_CLKS_PER_HALF_BIT = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_lead,
  output logic o_trail,
  output logic o_done
);

  localparam logic            CPOL    = cpol(2'(c_SPI_MODE));
  localparam int              HB_W    = $clog2(c_CLKS_PER_HALF_BIT);
  localparam int              EC_W    = $clog2(2 * c_WIDTH + 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(c_CLKS_PER_HALF_BIT - 1);
  localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * c_WIDTH - 1);
  localparam logic [EC_W-1:0] EC_END  = EC_W'(2 * c_WIDTH);

  logic [HB_W-1:0] hb_q, hb_d;
  logic [EC_W-1:0] ec_q, ec_d;
  logic            sclk_q, sclk_d;
  logic            edge_stb;

  always_comb begin
    edge_stb = i_en && (hb_q == HB_LAST) && (ec_q != EC_END);
    hb_d     = hb_q;
    ec_d     = ec_q;
    sclk_d   = sclk_q;
    // Disabled means parked: counters cleared and SCLK forced to its idle level.
    if (!i_en) begin
      hb_d   = '0;
      ec_d   = '0;
      sclk_d = CPOL;
    end else if (edge_stb) begin
      hb_d   = '0;
      ec_d   = ec_q + 1'b1;
      sclk_d = ~sclk_q;
    end else begin
      hb_d   = hb_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hb_q   <= '0;
      ec_q   <= '0;
      sclk_q <= CPOL;
    end else begin
      hb_q   <= hb_d;
      ec_q   <= ec_d;
      sclk_q <= sclk_d;
    end
  end

  assign o_sclk  = sclk_q;
  assign o_lead  = edge_stb && (sclk_q == CPOL);
  assign o_trail = edge_stb && (sclk_q != CPOL);
  assign o_done  = edge_stb && (ec_q == EC_LAST);

endmodule

// File: rtl/spi_master_cs.sv
// SPI master with chip select timing and multi-word bursts. CS_N is low for exactly
// SETUP + 2*WIDTH*CLKS + HOLD cycles per single-word burst; first SCLK edge is SETUP+CLKS after CS_N falls.
module spi_master_cs
  import spi_pkg::*;
#(
  parameter int c_SPI_MODE          = 0,
  parameter int c_WIDTH             = 8,
  parameter int c_CLKS_PER_HALF_BIT = 2,
  parameter int c_MSB_FIRST         = 1,
  parameter int c_CS_SETUP_CLKS     = 2,
  parameter int c_CS_HOLD_CLKS      = 2,
  parameter int c_CS_IDLE_CLKS      = 2
) (
  input  logic               i_CLK,
  input  logic               i_RESET_N,
  input  logic [c_WIDTH-1:0] i_TX_DATA,
  input  logic               i_TX_DV,
  input  logic               i_TX_LAST,
  output logic               o_TX_READY,
  output logic               o_RX_DV,
  output logic [c_WIDTH-1:0] o_RX_DATA,
  output logic               o_BUSY,
  input  logic               i_SPI_MISO,
  output logic               o_SPI_CLK,
  output logic               o_SPI_MOSI,
  output logic               o_SPI_CS_N
);

  localparam logic CPHA    = cpha(2'(c_SPI_MODE));
  localparam int   TIM_MAX = (c_CS_SETUP_CLKS > c_CS_HOLD_CLKS)
                           ? ((c_CS_SETUP_CLKS > c_CS_IDLE_CLKS) ? c_CS_SETUP_CLKS : c_CS_IDLE_CLKS)
                           : ((c_CS_HOLD_CLKS  > c_CS_IDLE_CLKS) ? c_CS_HOLD_CLKS  : c_CS_IDLE_CLKS);
  localparam int   TIM_W   = $clog2(TIM_MAX + 1);
  localparam logic [TIM_W-1:0] SETUP_LAST = TIM_W'(c_CS_SETUP_CLKS - 1);
  localparam logic [TIM_W-1:0] HOLD_LAST  = TIM_W'(c_CS_HOLD_CLKS - 1);
  localparam logic [TIM_W-1:0] IDLE_LAST  = TIM_W'(c_CS_IDLE_CLKS - 1);

  function automatic logic out_bit(input logic [c_WIDTH-1:0] sr);
    return (c_MSB_FIRST != 0) ? sr[c_WIDTH-1] : sr[0];
  endfunction

  function automatic logic [c_WIDTH-1:0] shift_out(input logic [c_WIDTH-1:0] sr);
    return (c_MSB_FIRST != 0) ? {sr[c_WIDTH-2:0], 1'b0} : {1'b0, sr[c_WIDTH-1:1]};
  endfunction

  function automatic logic [c_WIDTH-1:0] shift_in(input logic [c_WIDTH-1:0] sr, input logic b);
    return (c_MSB_FIRST != 0) ? {sr[c_WIDTH-2:0], b} : {b, sr[c_WIDTH-1:1]};
  endfunction

  state_e             state_q, state_d;
  logic [TIM_W-1:0]   tim_q, tim_d;
  logic [c_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [c_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [c_WIDTH-1:0] rx_data_q, rx_data_d;
  logic               rx_dv_q, rx_dv_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               last_q, last_d;
  logic               accept, lead, trail, done;

  spi_sclk_gen #(
    .c_SPI_MODE          (c_SPI_MODE),
    .c_WIDTH             (c_WIDTH),
    .c_CLKS_PER_HALF_BIT (c_CLKS_PER_HALF_BIT)
  ) u_sclk (
    .i_clk   (i_CLK),
    .i_rst_n (i_RESET_N),
    .i_en    (state_q == ST_SHIFT),
    .o_sclk  (o_SPI_CLK),
    .o_lead  (lead),
    .o_trail (trail),
    .o_done  (done)
  );

  always_comb begin
    accept    = i_TX_DV && ready_q;
    state_d   = state_q;
    tim_d     = tim_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    rx_dv_d   = 1'b0;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    last_d    = last_q;

    unique case (state_q)
      ST_IDLE: begin
        mosi_d = 1'b0;
        if (accept) begin
          state_d = ST_CS_SETUP;
          tim_d   = '0;
          cs_n_d  = 1'b0;
          last_d  = i_TX_LAST;
        end
      end
      ST_CS_SETUP: begin
        if (tim_q == SETUP_LAST) begin
          state_d = ST_SHIFT;
          tim_d   = '0;
        end else begin
          tim_d   = tim_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // CPHA picks which edge samples MISO; the other edge advances MOSI.
        if ((lead && !CPHA) || (trail && CPHA)) begin
          rx_sr_d = shift_in(rx_sr_q, i_SPI_MISO);
        end
        if ((trail && !CPHA) || (lead && CPHA)) begin
          mosi_d  = out_bit(tx_sr_q);
          tx_sr_d = shift_out(tx_sr_q);
        end
        if (done) begin
          rx_dv_d   = 1'b1;
          rx_data_d = rx_sr_d;
          tim_d     = '0;
          state_d   = last_q ? ST_CS_HOLD : ST_GAP;
        end
      end
      ST_GAP: begin
        if (accept) begin
          state_d = ST_SHIFT;
          last_d  = i_TX_LAST;
        end
      end
      ST_CS_HOLD: begin
        if (tim_q == HOLD_LAST) begin
          state_d = ST_CS_IDLE;
          tim_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          tim_d   = tim_q + 1'b1;
        end
      end
      ST_CS_IDLE: begin
        mosi_d = 1'b0;
        if (tim_q == IDLE_LAST) begin
          state_d = ST_IDLE;
          tim_d   = '0;
        end else begin
          tim_d   = tim_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CPHA=0 must present the first bit before the first edge, so it is driven at load.
    if (accept) begin
      if (CPHA) begin
        tx_sr_d = i_TX_DATA;
      end else begin
        tx_sr_d = shift_out(i_TX_DATA);
        mosi_d  = out_bit(i_TX_DATA);
      end
    end

    ready_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q   <= ST_IDLE;
      tim_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      rx_dv_q   <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tim_q     <= tim_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      rx_dv_q   <= rx_dv_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
    end
  end

  assign o_TX_READY = ready_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_DATA  = rx_data_q;
  assign o_BUSY     = busy_q;
  assign o_SPI_MOSI = mosi_q;
  assign o_SPI_CS_N = cs_n_q;

endmodule

// File: tb/tb_spi_master_cs.sv
// Directed bench: mode 0 loopback vectors, bursts, ignored writes and reset abort,
// plus a mode 3 instance with a slave model and a 16-bit LSB-first loopback instance.
module tb_spi_master_cs;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic rst0_n = 1'b0, rst_n = 1'b0;

  // Mode 0, 8-bit, MISO looped back from MOSI
  logic dv0 = 0, last0 = 0; logic [7:0] data0 = 0;
  logic ready0, rxdv0, busy0, mosi0, sclk0, csn0; logic [7:0] rxd0;
  spi_master_cs #(.c_SPI_MODE(0), .c_WIDTH(8)) u0 (
    .i_CLK(clk), .i_RESET_N(rst0_n), .i_TX_DATA(data0), .i_TX_DV(dv0), .i_TX_LAST(last0),
    .o_TX_READY(ready0), .o_RX_DV(rxdv0), .o_RX_DATA(rxd0), .o_BUSY(busy0),
    .i_SPI_MISO(mosi0), .o_SPI_CLK(sclk0), .o_SPI_MOSI(mosi0), .o_SPI_CS_N(csn0));

  // Mode 3, 8-bit, slave model answers 0x3C
  logic dv3 = 0, last3 = 0; logic [7:0] data3 = 0; logic miso3 = 0;
  logic ready3, rxdv3, busy3, mosi3, sclk3, csn3; logic [7:0] rxd3;
  spi_master_cs #(.c_SPI_MODE(3), .c_WIDTH(8)) u3 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_TX_DATA(data3), .i_TX_DV(dv3), .i_TX_LAST(last3),
    .o_TX_READY(ready3), .o_RX_DV(rxdv3), .o_RX_DATA(rxd3), .o_BUSY(busy3),
    .i_SPI_MISO(miso3), .o_SPI_CLK(sclk3), .o_SPI_MOSI(mosi3), .o_SPI_CS_N(csn3));

  // Mode 0, 16-bit, LSB first, loopback
  logic dv16 = 0, last16 = 0; logic [15:0] data16 = 0;
  logic ready16, rxdv16, busy16, mosi16, sclk16, csn16; logic [15:0] rxd16;
  spi_master_cs #(.c_SPI_MODE(0), .c_WIDTH(16), .c_MSB_FIRST(0)) u16 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_TX_DATA(data16), .i_TX_DV(dv16), .i_TX_LAST(last16),
    .o_TX_READY(ready16), .o_RX_DV(rxdv16), .o_RX_DATA(rxd16), .o_BUSY(busy16),
    .i_SPI_MISO(mosi16), .o_SPI_CLK(sclk16), .o_SPI_MOSI(mosi16), .o_SPI_CS_N(csn16));

  logic [7:0] sl_sr = 8'h3C;
  always @(negedge csn3) sl_sr = 8'h3C;
  always @(negedge sclk3) if (!csn3) begin miso3 = sl_sr[7]; sl_sr = {sl_sr[6:0], 1'b0}; end

  // Monitors sample at the falling clock edge
  logic p_sclk0 = 0, p_csn0 = 1, p_sclk3 = 1, p_sclk16 = 0;
  int rise0, tog0, wtog0, rxcnt0, cslow0, csrise0, lastedge0, csrisecyc0, rdybad0, idlebad0;
  logic [7:0] cap0; logic [7:0] rxh0 [4];
  int rise3, rxcnt3, idlebad3; logic [7:0] mcap3, scap3;
  int rise16, rxcnt16, cslow16; logic [15:0] cap16; logic bits16 [16];

  always @(negedge clk) begin
    cyc++;
    if (sclk0 != p_sclk0) begin
      tog0++; wtog0++; lastedge0 = cyc;
      if (sclk0) begin rise0++; cap0 = {cap0[6:0], mosi0}; end
    end
    if (!csn0) cslow0++;
    if (csn0 && !p_csn0) begin csrise0++; csrisecyc0 = cyc; end
    if (csn0 && sclk0) idlebad0++;
    if (!csn0 && wtog0 > 0 && wtog0 < 16 && ready0) rdybad0++;
    if (rxdv0) begin if (rxcnt0 < 4) rxh0[rxcnt0] = rxd0; rxcnt0++; wtog0 = 0; end
    p_sclk0 = sclk0; p_csn0 = csn0;

    if (sclk3 && !p_sclk3) begin rise3++; mcap3 = {mcap3[6:0], mosi3}; scap3 = {scap3[6:0], miso3}; end
    if (csn3 && !sclk3) idlebad3++;
    if (rxdv3) rxcnt3++;
    p_sclk3 = sclk3;

    if (sclk16 && !p_sclk16) begin
      if (rise16 < 16) bits16[rise16] = mosi16;
      rise16++; cap16 = {mosi16, cap16[15:1]};
    end
    if (!csn16) cslow16++;
    if (rxdv16) rxcnt16++;
    p_sclk16 = sclk16;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear0();
    rise0 = 0; tog0 = 0; wtog0 = 0; rxcnt0 = 0; cslow0 = 0; csrise0 = 0;
    lastedge0 = 0; csrisecyc0 = 0; rdybad0 = 0; idlebad0 = 0; cap0 = 0;
    for (int i = 0; i < 4; i++) rxh0[i] = 0;
  endtask

  task automatic send0(input logic [7:0] d, input logic l);
    int n; n = 0;
    while (!ready0 && n < 400) begin tick(); n++; end
    if (!ready0) chk("send0_ready_timeout", ready0, 1);
    data0 = d; last0 = l; dv0 = 1; tick(); dv0 = 0;
  endtask

  task automatic wait_idle0();
    int n; n = 0;
    while (busy0 && n < 400) begin tick(); n++; end
    chk("idle0_timeout", busy0, 0);
  endtask

  task automatic wait_rx0(input int k);
    int n; n = 0;
    while (rxcnt0 < k && n < 400) begin tick(); n++; end
    chk("rx0_timeout", rxcnt0 >= k, 1);
  endtask

  task automatic wait_tog0(input int k);
    int n; n = 0;
    while (tog0 < k && n < 400) begin tick(); n++; end
    chk("tog0_timeout", tog0 >= k, 1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int n;
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h00, 8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{8'h3C, 8'h3C, 8'h3C};
    vecs[4] = '{8'h81, 8'h81, 8'h81};
    vecs[5] = '{8'h6E, 8'h6E, 8'h6E};
    clear0();
    rise3 = 0; rxcnt3 = 0; idlebad3 = 0; mcap3 = 0; scap3 = 0;
    rise16 = 0; rxcnt16 = 0; cslow16 = 0; cap16 = 0;
    for (int i = 0; i < 16; i++) bits16[i] = 0;

    repeat (3) tick();
    chk("rst_sclk", sclk0, 0);
    chk("rst_csn", csn0, 1);
    chk("rst_mosi", mosi0, 0);
    chk("rst_ready", ready0, 1);
    chk("rst_rxdv", rxdv0, 0);
    chk("rst_rxdata", rxd0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_sclk_m3", sclk3, 1);
    rst0_n = 1; rst_n = 1;
    repeat (3) tick();

    for (int i = 0; i < 6; i++) begin
      clear0();
      send0(vecs[i].tx, 1'b1);
      wait_idle0();
      chk($sformatf("v%0d_rxdv_cnt", i), rxcnt0, 1);
      chk($sformatf("v%0d_rx", i), rxd0, vecs[i].exp_rx);
      chk($sformatf("v%0d_mosi", i), cap0, vecs[i].exp_mosi);
      chk($sformatf("v%0d_rises", i), rise0, 8);
      chk($sformatf("v%0d_cs_low", i), cslow0, 36);
      chk($sformatf("v%0d_cs_hold", i), csrisecyc0 - lastedge0, 2);
      chk($sformatf("v%0d_sclk_idle", i), idlebad0, 0);
      chk($sformatf("v%0d_mosi_idle", i), mosi0, 0);
    end

    // Three-word burst with gaps; CS must stay low throughout
    clear0();
    send0(8'h11, 1'b0);
    wait_rx0(1); repeat (5) tick();
    chk("burst_gap_csn", csn0, 0);
    chk("burst_gap_ready", ready0, 1);
    send0(8'h22, 1'b0);
    wait_rx0(2); repeat (5) tick();
    send0(8'h33, 1'b1);
    wait_idle0();
    chk("burst_rxdv_cnt", rxcnt0, 3);
    chk("burst_rx0", rxh0[0], 8'h11);
    chk("burst_rx1", rxh0[1], 8'h22);
    chk("burst_rx2", rxh0[2], 8'h33);
    chk("burst_cs_rises", csrise0, 1);
    chk("burst_edges", tog0, 48);
    chk("burst_cs_hold", csrisecyc0 - lastedge0, 2);
    chk("burst_ready_in_shift", rdybad0, 0);

    // Write attempt during SHIFT must be ignored
    clear0();
    send0(8'h5A, 1'b1);
    wait_tog0(3);
    chk("ign_ready_low", ready0, 0);
    data0 = 8'hEE; last0 = 1'b0; dv0 = 1; tick(); dv0 = 0;
    wait_idle0();
    chk("ign_rxdv_cnt", rxcnt0, 1);
    chk("ign_rx", rxd0, 8'h5A);
    chk("ign_mosi", cap0, 8'h5A);
    chk("ign_ready_in_shift", rdybad0, 0);
    repeat (20) tick();
    chk("ign_no_restart", busy0, 0);
    chk("ign_rxdv_after", rxcnt0, 1);

    // Reset mid-transfer after the 5th edge
    clear0();
    send0(8'h96, 1'b1);
    wait_tog0(5);
    rst0_n = 0; #1;
    chk("abort_csn", csn0, 1);
    chk("abort_sclk", sclk0, 0);
    chk("abort_ready", ready0, 1);
    chk("abort_busy", busy0, 0);
    chk("abort_rxdv", rxdv0, 0);
    chk("abort_rxdata", rxd0, 0);
    repeat (3) tick();
    rst0_n = 1;
    repeat (10) tick();
    chk("abort_no_rxdv", rxcnt0, 0);
    clear0();
    send0(8'hC3, 1'b1);
    wait_idle0();
    chk("post_abort_rx", rxd0, 8'hC3);
    chk("post_abort_rxdv_cnt", rxcnt0, 1);
    chk("post_abort_rises", rise0, 8);

    // Mode 3: master sends 0xFF, slave returns 0x3C
    n = 0;
    while (!ready3 && n < 400) begin tick(); n++; end
    data3 = 8'hFF; last3 = 1'b1; dv3 = 1; tick(); dv3 = 0;
    n = 0;
    while (busy3 && n < 400) begin tick(); n++; end
    chk("m3_idle_timeout", busy3, 0);
    chk("m3_rx", rxd3, 8'h3C);
    chk("m3_rxdv_cnt", rxcnt3, 1);
    chk("m3_rises", rise3, 8);
    chk("m3_mosi", mcap3, 8'hFF);
    chk("m3_miso_on_rise", scap3, 8'h3C);
    chk("m3_sclk_idle", idlebad3, 0);
    chk("m3_sclk_end", sclk3, 1);

    // 16-bit LSB first loopback of 0x8001
    n = 0;
    while (!ready16 && n < 400) begin tick(); n++; end
    data16 = 16'h8001; last16 = 1'b1; dv16 = 1; tick(); dv16 = 0;
    n = 0;
    while (busy16 && n < 400) begin tick(); n++; end
    chk("w16_idle_timeout", busy16, 0);
    chk("w16_first_bit", bits16[0], 1);
    chk("w16_second_bit", bits16[1], 0);
    chk("w16_last_bit", bits16[15], 1);
    chk("w16_mosi_word", cap16, 16'h8001);
    chk("w16_rx", rxd16, 16'h8001);
    chk("w16_rxdv_cnt", rxcnt16, 1);
    chk("w16_rises", rise16, 16);
    chk("w16_cs_low", cslow16, 68);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
